multicycle_sequencer: RTL and testbench

- Multi-cycle control FSM for the MIPS-basic datapath. Runs each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the existing datapath strobes one phase at a time, so instruction and data can share one memory port with a ready handshake.
- Sits between the shared memory port, the IR/PC registers and the ALU/register-file controls. Replaces single-cycle combinational control when memory latency is variable.

---
 rtl/multicycle_sequencer_pkg.sv | 59 +++++
 rtl/multicycle_sequencer_op_decode.sv | 45 ++++
 rtl/multicycle_sequencer.sv | 158 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle MIPS-basic control sequencer:
// state encoding, opcode and ALU-control constants, decoded-opcode record.
package multicycle_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      CLS_ALU = 2'd0,
      CLS_LW  = 2'd1,
      CLS_SW  = 2'd2
   } op_class_e;

   localparam logic [5:0] OP_ADD  = 6'b000001;
   localparam logic [5:0] OP_SUB  = 6'b000010;
   localparam logic [5:0] OP_INC  = 6'b000011;
   localparam logic [5:0] OP_DEC  = 6'b000100;
   localparam logic [5:0] OP_AND  = 6'b000101;
   localparam logic [5:0] OP_OR   = 6'b000110;
   localparam logic [5:0] OP_XOR  = 6'b000111;
   localparam logic [5:0] OP_NOT  = 6'b001000;
   localparam logic [5:0] OP_SLL  = 6'b001001;
   localparam logic [5:0] OP_SRL  = 6'b001010;
   localparam logic [5:0] OP_ADDI = 6'b001011;
   localparam logic [5:0] OP_SUBI = 6'b001100;
   localparam logic [5:0] OP_CMP  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100010;
   localparam logic [5:0] OP_SW   = 6'b100100;

   localparam logic [3:0] ALU_NOT = 4'b0000;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_DEC = 4'b0100;
   localparam logic [3:0] ALU_ADD = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_INC = 4'b0111;
   localparam logic [3:0] ALU_CMP = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRL = 4'b1010;

   typedef struct packed {
      logic       legal;
      op_class_e  cls;
      logic [3:0] alu_ctrl;
      logic       alu_src;
      logic       shamt_sel;
      logic       reg_dst;
      logic       mem_to_reg;
   } dec_t;

endpackage

// File: rtl/multicycle_sequencer_op_decode.sv
// Combinational opcode decoder: legality, instruction class and the
// datapath selects / ALU operation associated with each opcode.
module op_decode
   import multicycle_sequencer_pkg::*;
(
   input  logic [5:0] opcode_i,
   output dec_t       dec_o
);

   always_comb begin
      dec_o       = '0;
      dec_o.legal = 1'b1;
      dec_o.cls   = CLS_ALU;
      case (opcode_i)
         OP_ADD, OP_ADDI: dec_o.alu_ctrl = ALU_ADD;
         OP_SUB, OP_SUBI: dec_o.alu_ctrl = ALU_SUB;
         OP_INC:          dec_o.alu_ctrl = ALU_INC;
         OP_DEC:          dec_o.alu_ctrl = ALU_DEC;
         OP_AND:          dec_o.alu_ctrl = ALU_AND;
         OP_OR:           dec_o.alu_ctrl = ALU_OR;
         OP_XOR:          dec_o.alu_ctrl = ALU_XOR;
         OP_NOT:          dec_o.alu_ctrl = ALU_NOT;
         OP_SLL:          dec_o.alu_ctrl = ALU_SLL;
         OP_SRL:          dec_o.alu_ctrl = ALU_SRL;
         OP_CMP:          dec_o.alu_ctrl = ALU_CMP;
         OP_LW: begin
            dec_o.cls      = CLS_LW;
            dec_o.alu_ctrl = ALU_ADD;
         end
         OP_SW: begin
            dec_o.cls      = CLS_SW;
            dec_o.alu_ctrl = ALU_ADD;
         end
         default: begin
            dec_o.legal = 1'b0;
            dec_o.cls   = CLS_ALU;
         end
      endcase
      dec_o.alu_src    = opcode_i inside {OP_ADDI, OP_SUBI, OP_LW, OP_SW};
      dec_o.shamt_sel  = opcode_i inside {OP_SLL, OP_SRL};
      dec_o.reg_dst    = dec_o.legal && (dec_o.cls == CLS_ALU);
      dec_o.mem_to_reg = dec_o.legal && (dec_o.cls == CLS_ALU);
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the MIPS-basic datapath,
// sharing one memory port between instruction and data via a ready handshake.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TIMEOUT_W   = 4
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Run,
   input  logic       Clear,
   input  logic [5:0] Opcode,
   input  logic       Mem_Ready,
   output logic       PC_Write,
   output logic       IR_Write,
   output logic       Instr_Sel,
   output logic       Mem_Read,
   output logic       Mem_Write,
   output logic       Reg_Dst,
   output logic       Alu_Src,
   output logic       Mem_To_Reg,
   output logic       Shamt_Sel,
   output logic [3:0] Alu_Control,
   output logic       Reg_Write,
   output logic       Instr_Done,
   output logic       Illegal_Op,
   output logic       Timeout,
   output logic       Busy
);

   localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

   state_e               state_q, state_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic [5:0]           op_q, op_d;
   logic                 ill_q, ill_d;
   logic                 tmo_q, tmo_d;
   logic [5:0]           dec_op;
   dec_t                 dec;
   logic                 cnt_last;
   logic                 sel_on;

   // One decoder serves both uses: the live opcode while in DECODE, the latched one afterwards.
   assign dec_op   = (state_q == S_DECODE) ? Opcode : op_q;
   assign cnt_last = (cnt_q == CNT_LAST);

   op_decode u_op_decode (
      .opcode_i (dec_op),
      .dec_o    (dec)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      op_d    = op_q;
      ill_d   = ill_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: if (Run) state_d = S_FETCH;
         S_FETCH: begin
            if (Mem_Ready) begin
               state_d = S_DECODE;
            end else if (cnt_last) begin
               state_d = S_ERR;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
         end
         S_DECODE: begin
            op_d = Opcode;
            if (dec.legal) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_ERR;
               ill_d   = 1'b1;
            end
         end
         S_EXEC: state_d = (dec.cls == CLS_ALU) ? S_WB : S_MEM;
         S_MEM: begin
            if (Mem_Ready) begin
               if (dec.cls == CLS_LW) state_d = S_WB;
               else                   state_d = Run ? S_FETCH : S_IDLE;
            end else if (cnt_last) begin
               state_d = S_ERR;
               tmo_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + TIMEOUT_W'(1);
            end
         end
         S_WB: state_d = Run ? S_FETCH : S_IDLE;
         S_ERR: begin
            if (Clear) begin
               state_d = S_IDLE;
               ill_d   = 1'b0;
               tmo_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         ill_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         ill_q   <= ill_d;
         tmo_q   <= tmo_d;
      end
   end

   assign sel_on = state_q inside {S_EXEC, S_MEM, S_WB};

   always_comb begin
      PC_Write    = 1'b0;
      IR_Write    = 1'b0;
      Instr_Sel   = 1'b0;
      Mem_Read    = 1'b0;
      Mem_Write   = 1'b0;
      Reg_Write   = 1'b0;
      Instr_Done  = 1'b0;
      Reg_Dst     = sel_on & dec.reg_dst;
      Alu_Src     = sel_on & dec.alu_src;
      Mem_To_Reg  = sel_on & dec.mem_to_reg;
      Shamt_Sel   = sel_on & dec.shamt_sel;
      Alu_Control = sel_on ? dec.alu_ctrl : '0;
      case (state_q)
         S_FETCH: begin
            Instr_Sel = 1'b1;
            Mem_Read  = 1'b1;
            IR_Write  = Mem_Ready;
            PC_Write  = Mem_Ready;
         end
         S_MEM: begin
            Mem_Read   = (dec.cls == CLS_LW);
            Mem_Write  = (dec.cls == CLS_SW);
            Instr_Done = (dec.cls == CLS_SW) & Mem_Ready;
         end
         S_WB: begin
            Reg_Write  = 1'b1;
            Instr_Done = 1'b1;
         end
         default: ;
      endcase
      Illegal_Op = ill_q;
      Timeout    = tmo_q;
      Busy       = !(state_q inside {S_IDLE, S_ERR});
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench: each instruction is expanded into its phase schedule from
// the opcode rules and memory wait counts, and every cycle's outputs are checked.
module tb_multicycle_sequencer;

   localparam int unsigned TMO = 15;
   localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_ERR = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       Run = 1'b0, Clear = 1'b0, Mem_Ready = 1'b0;
   logic [5:0] Opcode = '0;
   logic       PC_Write, IR_Write, Instr_Sel, Mem_Read, Mem_Write;
   logic       Reg_Dst, Alu_Src, Mem_To_Reg, Shamt_Sel;
   logic [3:0] Alu_Control;
   logic       Reg_Write, Instr_Done, Illegal_Op, Timeout, Busy;
   logic [17:0] dut_vec;

   int unsigned n_pass = 0, n_total = 0;
   logic        m_ill = 1'b0, m_tmo = 1'b0;
   logic [5:0]  lat_op = '0;
   logic        in_idle, ended_err;
   logic [5:0]  legal_ops [15] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8,
                                   6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd34, 6'd36};

   multicycle_sequencer #(.MEM_TIMEOUT(15), .TIMEOUT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .Run(Run), .Clear(Clear), .Opcode(Opcode),
      .Mem_Ready(Mem_Ready), .PC_Write(PC_Write), .IR_Write(IR_Write),
      .Instr_Sel(Instr_Sel), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
      .Reg_Dst(Reg_Dst), .Alu_Src(Alu_Src), .Mem_To_Reg(Mem_To_Reg),
      .Shamt_Sel(Shamt_Sel), .Alu_Control(Alu_Control), .Reg_Write(Reg_Write),
      .Instr_Done(Instr_Done), .Illegal_Op(Illegal_Op), .Timeout(Timeout), .Busy(Busy)
   );

   always #5 clk = ~clk;

   assign dut_vec = {PC_Write, IR_Write, Instr_Sel, Mem_Read, Mem_Write, Reg_Dst, Alu_Src,
                     Mem_To_Reg, Shamt_Sel, Alu_Control, Reg_Write, Instr_Done,
                     Illegal_Op, Timeout, Busy};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return (op >= 6'd1 && op <= 6'd13) || op == 6'd34 || op == 6'd36;
   endfunction

   function automatic logic [3:0] alu_of(input logic [5:0] op);
      case (op)
         6'd1, 6'd11, 6'd34, 6'd36: return 4'b0101;
         6'd2, 6'd12: return 4'b0110;
         6'd3:  return 4'b0111;
         6'd4:  return 4'b0100;
         6'd5:  return 4'b0001;
         6'd6:  return 4'b0011;
         6'd7:  return 4'b0010;
         6'd8:  return 4'b0000;
         6'd9:  return 4'b1001;
         6'd10: return 4'b1010;
         6'd13: return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [17:0] exp_vec(input int ph, input logic rdy);
      logic pcw, irw, isel, mrd, mwr, rd, src, mtr, sh, rw, done, mem;
      logic [3:0] alu;
      {pcw, irw, isel, mrd, mwr, rd, src, mtr, sh, rw, done} = '0;
      alu = '0;
      mem = (lat_op == 6'd34) || (lat_op == 6'd36);
      if (ph == P_FETCH) begin
         isel = 1'b1; mrd = 1'b1; pcw = rdy; irw = rdy;
      end
      if (ph == P_EXEC || ph == P_MEM || ph == P_WB) begin
         alu = alu_of(lat_op);
         src = mem || lat_op == 6'd11 || lat_op == 6'd12;
         sh  = lat_op == 6'd9 || lat_op == 6'd10;
         rd  = !mem;
         mtr = !mem;
      end
      if (ph == P_MEM) begin
         mrd  = (lat_op == 6'd34);
         mwr  = (lat_op == 6'd36);
         done = (lat_op == 6'd36) && rdy;
      end
      if (ph == P_WB) begin
         rw = 1'b1; done = 1'b1;
      end
      return {pcw, irw, isel, mrd, mwr, rd, src, mtr, sh, alu, rw, done,
              (ph == P_ERR) && m_ill, (ph == P_ERR) && m_tmo,
              (ph != P_IDLE) && (ph != P_ERR)};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] ro();
      return 6'($urandom);
   endfunction

   // Called at a falling edge: drive this cycle's inputs, check, advance one cycle.
   task automatic step(input int ph, input logic rdy, input logic run, input logic clr,
                       input logic [5:0] op, input string tag);
      Run = run; Clear = clr; Mem_Ready = rdy; Opcode = op;
      if (ph == P_DEC) lat_op = op;
      #2;
      check(tag, 32'(dut_vec), 32'(exp_vec(ph, rdy)));
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [5:0] op, input int unsigned wf, input int unsigned wm,
                            input logic run_last, output logic err);
      logic lw, sw;
      lw  = (op == 6'd34);
      sw  = (op == 6'd36);
      err = 1'b0;
      for (int unsigned i = 0; i < wf && i < TMO; i++) step(P_FETCH, 1'b0, rb(), rb(), ro(), "fetch_wait");
      if (wf >= TMO) begin m_tmo = 1'b1; err = 1'b1; return; end
      step(P_FETCH, 1'b1, rb(), rb(), ro(), "fetch");
      step(P_DEC, rb(), rb(), rb(), op, "decode");
      if (!is_legal(op)) begin m_ill = 1'b1; err = 1'b1; return; end
      step(P_EXEC, rb(), rb(), rb(), ro(), "exec");
      if (lw || sw) begin
         for (int unsigned i = 0; i < wm && i < TMO; i++) step(P_MEM, 1'b0, rb(), rb(), ro(), "mem_wait");
         if (wm >= TMO) begin m_tmo = 1'b1; err = 1'b1; return; end
         step(P_MEM, 1'b1, sw ? run_last : rb(), rb(), ro(), "mem");
         if (sw) return;
      end
      step(P_WB, rb(), run_last, rb(), ro(), "wb");
   endtask

   task automatic err_seq();
      repeat ($urandom_range(1, 3)) step(P_ERR, rb(), 1'b1, 1'b0, ro(), "err_hold");
      step(P_ERR, rb(), rb(), 1'b1, ro(), "err_clear");
      m_ill = 1'b0;
      m_tmo = 1'b0;
   endtask

   task automatic enter_fetch();
      repeat ($urandom_range(0, 2)) step(P_IDLE, rb(), 1'b0, rb(), ro(), "idle");
      step(P_IDLE, rb(), 1'b1, rb(), ro(), "idle_go");
   endtask

   task automatic one(input logic [5:0] op, input int unsigned wf, input int unsigned wm,
                      input logic run_last);
      if (in_idle) enter_fetch();
      run_instr(op, wf, wm, run_last, ended_err);
      if (ended_err) err_seq();
      in_idle = ended_err || !run_last;
   endtask

   initial begin
      logic [5:0] op;
      int unsigned wf, wm;
      Run = 1'b1; Mem_Ready = 1'b1; Opcode = 6'd1;
      repeat (3) begin
         @(negedge clk); #2;
         check("reset_outputs", 32'(dut_vec), 32'd0);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      in_idle = 1'b1;

      one(6'd1,  0, 0, 1'b1);     // ADD, zero wait
      one(6'd34, 0, 3, 1'b1);     // LW, three MEM wait cycles
      one(6'd36, 0, 0, 1'b1);     // SW, zero wait
      one(6'd63, 0, 0, 1'b1);     // illegal opcode
      one(6'd1,  TMO, 0, 1'b1);   // FETCH timeout
      one(6'd9,  1, 0, 1'b0);     // SLL then back to IDLE
      one(6'd34, 0, TMO, 1'b1);   // MEM timeout

      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            do op = ro(); while (is_legal(op));
         end else begin
            op = legal_ops[$urandom_range(0, 14)];
         end
         wf = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3);
         wm = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, 3);
         one(op, wf, wm, 1'($urandom_range(0, 3) != 0));
      end

      // Reset asserted while an SW write is waiting in MEM.
      if (in_idle) enter_fetch();
      step(P_FETCH, 1'b1, 1'b1, 1'b0, ro(), "rst_fetch");
      step(P_DEC, 1'b0, 1'b1, 1'b0, 6'd36, "rst_decode");
      step(P_EXEC, 1'b0, 1'b1, 1'b0, ro(), "rst_exec");
      step(P_MEM, 1'b0, 1'b1, 1'b0, ro(), "rst_mem");
      rst_n = 1'b0;
      #1;
      check("rst_mem_write", 32'(Mem_Write), 32'd0);
      check("rst_midop_outputs", 32'(dut_vec), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lat_op = '0;
      step(P_IDLE, 1'b0, 1'b0, 1'b0, ro(), "post_rst_idle");
      step(P_IDLE, 1'b0, 1'b1, 1'b0, ro(), "post_rst_go");
      step(P_FETCH, 1'b1, 1'b0, 1'b0, ro(), "post_rst_fetch");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
